// File: rtl/dl_rst_seq.sv
// dl_rst_seq - reset sequencer feeding the rst_n inputs of core logic.
//
// Resets are asserted asynchronously, and release is synchronized to clk.
// After release, reset is held for a minimum period. The NUM_OUTS reset
// domains are then released in a staggered order, and completion is flagged.
//
// Ports:
//   clk         single clock; all state changes on posedge
//   rst_n       master reset, active-low, asynchronous assert
//   sw_rst_req  synchronous software reset request, active-high
//   rst_n_out   per-domain active-low reset; bit 0 is released first
//   rst_done    high once every domain is released
//
// state   | meaning
// --------+-----------------------------------------------------------
// SYNC    | waiting for the deassertion synchronizer to fill with ones
// HOLD    | all domains held in reset for HOLD_CYCLES edges
// RELEASE | releasing domains 1..NUM_OUTS-1 every STAGGER_CYCLES edges
// DONE    | all domains released, rst_done high

module dl_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int NUM_OUTS       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic                rst_done
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_OUTS + 1);

  if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || NUM_OUTS < 1) begin : g_bad_params
    $error("dl_rst_seq: illegal parameter value");
  end

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTS-1:0]    out_q, out_d;
  logic                   done_q, done_d;
  logic                   sync_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // The last stage goes high on the edge that this term is sampled high.
  // Leaving SYNC on that same edge makes HOLD start counting on the
  // next edge, so rst_n_out[0] rises at edge SYNC_STAGES + HOLD_CYCLES.
  assign sync_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;

    if (sw_rst_req && state_q != SYNC) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          if (sync_rise) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            out_d[0] = 1'b1;
            idx_d    = IW'(1);
            cnt_d    = '0;
            state_d  = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          // idx_q is the next domain to release; reaching NUM_OUTS means all are out.
          if (idx_q == IW'(NUM_OUTS)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
            for (int i = 0; i < NUM_OUTS; i++) begin
              if (IW'(i) == idx_q) out_d[i] = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_n_out = out_q;
  assign rst_done  = done_q;

endmodule

// File: tb/tb_dl_rst_seq.sv
module tb_dl_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_n_out;
  logic       rst_done;

  logic       rst2_n = 1'b0;
  logic       sw2 = 1'b0;
  logic [0:0] out2;
  logic       done2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dl_rst_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (rst_n_out),
    .rst_done   (rst_done)
  );

  dl_rst_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(4), .NUM_OUTS(1)) dut_min (
    .clk        (clk),
    .rst_n      (rst2_n),
    .sw_rst_req (sw2),
    .rst_n_out  (out2),
    .rst_done   (done2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rst_n_out !== 3'b000) begin
      failures++;
      $display("FAIL reset_out got=%b exp=000", rst_n_out);
    end
    checks++;
    if (rst_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", rst_done);
    end
    checks++;
    if (out2 !== 1'b0 || done2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_min got=%b/%b exp=0/0", out2, done2);
    end
  endtask

  task automatic test_power_on();
    logic [2:0] eo;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) eo[i] = (e >= 18 + 4 * i);
      checks++;
      if (rst_n_out !== eo || rst_done !== (e >= 27)) begin
        failures++;
        $display("FAIL power_on edge=%0d got=%b/%b exp=%b/%b", e, rst_n_out, rst_done, eo, (e >= 27));
      end
    end
  endtask

  task automatic test_async_mid_release();
    logic [2:0] eo;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (23) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (rst_n_out !== 3'b000 || rst_done !== 1'b0) begin
      failures++;
      $display("FAIL async_assert got=%b/%b exp=000/0", rst_n_out, rst_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) eo[i] = (e >= 18 + 4 * i);
      checks++;
      if (rst_n_out !== eo || rst_done !== (e >= 27)) begin
        failures++;
        $display("FAIL async_replay edge=%0d got=%b/%b exp=%b/%b", e, rst_n_out, rst_done, eo, (e >= 27));
      end
    end
  endtask

  task automatic test_sw_in_done();
    logic [2:0] eo;
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rst_n_out !== 3'b000 || rst_done !== 1'b0) begin
      failures++;
      $display("FAIL sw_done_assert got=%b/%b exp=000/0", rst_n_out, rst_done);
    end
    @(negedge clk);
    sw_rst_req = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) eo[i] = (j >= 16 + 4 * i);
      checks++;
      if (rst_n_out !== eo || rst_done !== (j >= 25)) begin
        failures++;
        $display("FAIL sw_done k+%0d got=%b/%b exp=%b/%b", j, rst_n_out, rst_done, eo, (j >= 25));
      end
    end
  endtask

  task automatic test_sw_held_in_release();
    logic [2:0] eo;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rst_n_out !== 3'b001) begin
      failures++;
      $display("FAIL sw_rel_pre got=%b exp=001", rst_n_out);
    end
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      sw_rst_req = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rst_n_out !== 3'b000 || rst_done !== 1'b0) begin
        failures++;
        $display("FAIL sw_rel_held k+%0d got=%b/%b exp=000/0", r, rst_n_out, rst_done);
      end
    end
    @(negedge clk);
    sw_rst_req = 1'b0;
    for (int rel = 5; rel <= 30; rel++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) eo[i] = (rel >= 20 + 4 * i);
      checks++;
      if (rst_n_out !== eo || rst_done !== (rel >= 29)) begin
        failures++;
        $display("FAIL sw_rel k+%0d got=%b/%b exp=%b/%b", rel, rst_n_out, rst_done, eo, (rel >= 29));
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] eo;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rst_n_out !== 3'b000 || rst_done !== 1'b0) begin
      failures++;
      $display("FAIL glitch_assert got=%b/%b exp=000/0", rst_n_out, rst_done);
    end
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) eo[i] = (e >= 18 + 4 * i);
      checks++;
      if (rst_n_out !== eo || rst_done !== (e >= 27)) begin
        failures++;
        $display("FAIL glitch_replay edge=%0d got=%b/%b exp=%b/%b", e, rst_n_out, rst_done, eo, (e >= 27));
      end
    end
  endtask

  task automatic test_sw_in_sync();
    logic [2:0] eo;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sw_rst_req = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 2) sw_rst_req = 1'b0;
      for (int i = 0; i < 3; i++) eo[i] = (e >= 18 + 4 * i);
      checks++;
      if (rst_n_out !== eo || rst_done !== (e >= 27)) begin
        failures++;
        $display("FAIL sw_in_sync edge=%0d got=%b/%b exp=%b/%b", e, rst_n_out, rst_done, eo, (e >= 27));
      end
    end
  endtask

  task automatic test_min_config();
    rst2_n = 1'b0;
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      checks++;
      if (out2 !== 1'((e >= 4)) || done2 !== (e >= 5)) begin
        failures++;
        $display("FAIL min_cfg edge=%0d got=%b/%b exp=%b/%b", e, out2, done2, (e >= 4), (e >= 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_async_mid_release();
    test_sw_in_done();
    test_sw_held_in_release();
    test_glitch();
    test_sw_in_sync();
    test_min_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
